// File: rtl/wb_regfile_if.sv
// wb_regfile_if -- bundles the writeback, issue and read-port signals of the
// register file with its scoreboard.
//   Writeback : RegWriteW, MemtoRegW, ReadDataW[31:0], ALUOutW[31:0], WriteRegW[4:0]
//   Read ports: A1[4:0], A2[4:0] -> RD1[31:0], RD2[31:0], Busy1, Busy2
//   Issue     : IssueValid, IssueReg[4:0]
//   Status    : ResultW[31:0], RetireCount[31:0], Overflow, Underflow
// The master modport is the pipeline side; the slave modport is the regfile.
interface wb_regfile_if;
  logic        RegWriteW;
  logic        MemtoRegW;
  logic [31:0] ReadDataW;
  logic [31:0] ALUOutW;
  logic [4:0]  WriteRegW;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic        IssueValid;
  logic [4:0]  IssueReg;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic        Busy1;
  logic        Busy2;
  logic [31:0] ResultW;
  logic [31:0] RetireCount;
  logic        Overflow;
  logic        Underflow;

  modport master (
    output RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW, A1, A2,
           IssueValid, IssueReg,
    input  RD1, RD2, Busy1, Busy2, ResultW, RetireCount, Overflow, Underflow
  );

  modport slave (
    input  RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW, A1, A2,
           IssueValid, IssueReg,
    output RD1, RD2, Busy1, Busy2, ResultW, RetireCount, Overflow, Underflow
  );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile -- 32 x 32-bit register file with writeback bypass and a
// per-register pending-write scoreboard (2-bit saturating counts).
//   clk : rising-edge clock for all state
//   rst : asynchronous active-high reset, clears every register and flag
//   bus : wb_regfile_if.slave (writeback, issue, read ports, status outputs)
// Reads, ResultW and Busy are combinational; writes, counts, RetireCount and
// the sticky Overflow/Underflow flags update on the clock edge.
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  wb_regfile_if.slave bus
);

  logic [31:0][31:0] regs;
  logic [31:0][1:0]  pending;
  logic [31:0]       retireCount;
  logic              overflow;
  logic              underflow;

  logic [31:0] resultW;
  logic        retireEv;
  logic        issueEv;
  logic        sameReg;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        busy1;
  logic        busy2;

  // Busy when more than one write is outstanding, or exactly one that is
  // not being retired right now. Register 0 is never busy.
  function automatic logic busyFor(input logic [4:0] a, input logic [1:0] cnt,
                                   input logic retireHit);
    logic b;
    if (a == 5'd0) begin
      b = 1'b0;
    end else if (cnt >= 2'd2) begin
      b = 1'b1;
    end else if (cnt == 2'd1) begin
      b = ~retireHit;
    end else begin
      b = 1'b0;
    end
    return b;
  endfunction

  // Writeback result select and event decode.
  always_comb begin
    resultW  = bus.MemtoRegW ? bus.ReadDataW : bus.ALUOutW;
    retireEv = bus.RegWriteW && (bus.WriteRegW != 5'd0);
    issueEv  = bus.IssueValid && (bus.IssueReg != 5'd0);
    // Issue and retire to one register cancel out, so neither update applies.
    sameReg  = issueEv && retireEv && (bus.IssueReg == bus.WriteRegW);
  end

  // Read ports with same-cycle bypass of the value being written back.
  always_comb begin
    rd1 = 32'd0;
    rd2 = 32'd0;
    if (bus.A1 == 5'd0) begin
      rd1 = 32'd0;
    end else if (retireEv && (bus.WriteRegW == bus.A1)) begin
      rd1 = resultW;
    end else begin
      rd1 = regs[bus.A1];
    end
    if (bus.A2 == 5'd0) begin
      rd2 = 32'd0;
    end else if (retireEv && (bus.WriteRegW == bus.A2)) begin
      rd2 = resultW;
    end else begin
      rd2 = regs[bus.A2];
    end
  end

  // Operand busy flags from the scoreboard counts.
  always_comb begin
    busy1 = busyFor(bus.A1, pending[bus.A1], retireEv && (bus.WriteRegW == bus.A1));
    busy2 = busyFor(bus.A2, pending[bus.A2], retireEv && (bus.WriteRegW == bus.A2));
  end

  // Register storage, scoreboard counts, retire counter and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs        <= '0;
      pending     <= '0;
      retireCount <= 32'd0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (retireEv) begin
        regs[bus.WriteRegW] <= resultW;
        retireCount         <= retireCount + 32'd1;
      end
      if (issueEv && !sameReg) begin
        if (pending[bus.IssueReg] == 2'd3) begin
          overflow <= 1'b1;
        end else begin
          pending[bus.IssueReg] <= pending[bus.IssueReg] + 2'd1;
        end
      end
      // The register write above still happens on an underflowing retire.
      if (retireEv && !sameReg) begin
        if (pending[bus.WriteRegW] == 2'd0) begin
          underflow <= 1'b1;
        end else begin
          pending[bus.WriteRegW] <= pending[bus.WriteRegW] - 2'd1;
        end
      end
    end
  end

  assign bus.ResultW     = resultW;
  assign bus.RD1         = rd1;
  assign bus.RD2         = rd2;
  assign bus.Busy1       = busy1;
  assign bus.Busy2       = busy2;
  assign bus.RetireCount = retireCount;
  assign bus.Overflow    = overflow;
  assign bus.Underflow   = underflow;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile -- scoreboard bench for wb_regfile. The driver applies one
// stimulus vector per cycle shortly after the falling edge, predicts the
// combinational outputs from a behavioural model and queues them; a monitor
// compares the queued prediction with the DUT a little later in the cycle.
module tb_wb_regfile;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] res;
    logic [31:0] rc;
    logic        b1;
    logic        b2;
    logic        ov;
    logic        un;
  } exp_t;

  exp_t expQ[$];
  int total = 0;
  int bad = 0;
  int pushed = 0;
  int popped = 0;

  // Behavioural model state.
  logic [31:0] mRegs [32];
  int          mCnt  [32];
  logic [31:0] mRc;
  logic        mOv;
  logic        mUn;

  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin
      mRegs[i] = 32'd0;
      mCnt[i]  = 0;
    end
    mRc = 32'd0;
    mOv = 1'b0;
    mUn = 1'b0;
  endtask

  function automatic logic [31:0] expRead(input logic [4:0] a, input bit ret,
                                          input logic [4:0] wreg, input logic [31:0] res);
    if (a == 5'd0) return 32'd0;
    if (ret && wreg == a) return res;
    return mRegs[a];
  endfunction

  function automatic logic expBusy(input logic [4:0] a, input bit ret, input logic [4:0] wreg);
    if (a == 5'd0) return 1'b0;
    if (mCnt[a] >= 2) return 1'b1;
    if (mCnt[a] == 1 && !(ret && wreg == a)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input logic rw, input logic m2r, input logic [31:0] rdata,
                       input logic [31:0] alu, input logic [4:0] wreg,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic iv, input logic [4:0] ireg, input logic r);
    exp_t e;
    logic [31:0] res;
    bit ret;
    bit iss;
    @(negedge clk);
    #1;
    bus.RegWriteW  = rw;
    bus.MemtoRegW  = m2r;
    bus.ReadDataW  = rdata;
    bus.ALUOutW    = alu;
    bus.WriteRegW  = wreg;
    bus.A1         = a1;
    bus.A2         = a2;
    bus.IssueValid = iv;
    bus.IssueReg   = ireg;
    rst            = r;
    if (r) modelReset();
    res = m2r ? rdata : alu;
    ret = rw && (wreg != 5'd0);
    iss = iv && (ireg != 5'd0);
    e.res = res;
    e.rd1 = expRead(a1, ret, wreg, res);
    e.rd2 = expRead(a2, ret, wreg, res);
    e.b1  = expBusy(a1, ret, wreg);
    e.b2  = expBusy(a2, ret, wreg);
    e.rc  = mRc;
    e.ov  = mOv;
    e.un  = mUn;
    expQ.push_back(e);
    pushed++;
    // State change at the coming edge (none while reset is held).
    if (!r) begin
      if (ret) begin
        mRegs[wreg] = res;
        mRc = mRc + 32'd1;
      end
      for (int k = 1; k < 32; k++) begin
        int d;
        d = ((iss && ireg == k) ? 1 : 0) - ((ret && wreg == k) ? 1 : 0);
        if (d > 0) begin
          if (mCnt[k] == 3) mOv = 1'b1;
          else mCnt[k] = mCnt[k] + 1;
        end else if (d < 0) begin
          if (mCnt[k] == 0) mUn = 1'b1;
          else mCnt[k] = mCnt[k] - 1;
        end
      end
    end
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, a1, a2, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic issue(input logic [4:0] r, input logic [4:0] a1, input logic [4:0] a2);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, a1, a2, 1'b1, r, 1'b0);
  endtask

  task automatic retire(input logic [4:0] r, input logic [31:0] v,
                        input logic [4:0] a1, input logic [4:0] a2);
    drive(1'b1, 1'b0, 32'hA5A5_0000, v, r, a1, a2, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic chk(input string name, input int step,
                     input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", name, step, act, want);
    end
  endtask

  // Monitor: compare the prediction for this cycle once inputs have settled.
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      chk("ResultW", popped, bus.ResultW, e.res);
      chk("RD1", popped, bus.RD1, e.rd1);
      chk("RD2", popped, bus.RD2, e.rd2);
      chk("Busy1", popped, {31'd0, bus.Busy1}, {31'd0, e.b1});
      chk("Busy2", popped, {31'd0, bus.Busy2}, {31'd0, e.b2});
      chk("RetireCount", popped, bus.RetireCount, e.rc);
      chk("Overflow", popped, {31'd0, bus.Overflow}, {31'd0, e.ov});
      chk("Underflow", popped, {31'd0, bus.Underflow}, {31'd0, e.un});
      popped++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit forced;
    bus.RegWriteW  = 1'b0;
    bus.MemtoRegW  = 1'b0;
    bus.ReadDataW  = 32'd0;
    bus.ALUOutW    = 32'd0;
    bus.WriteRegW  = 5'd0;
    bus.A1         = 5'd0;
    bus.A2         = 5'd0;
    bus.IssueValid = 1'b0;
    bus.IssueReg   = 5'd0;
    modelReset();

    // Reset state, then release.
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd1, 5'd2, 1'b1, 5'd1, 1'b1);
    idle(5'd1, 5'd2);

    // Bypass then storage read of reg5.
    drive(1'b1, 1'b0, 32'h1111_2222, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
    idle(5'd5, 5'd0);

    // Write to reg0 is dropped and not counted.
    drive(1'b1, 1'b1, 32'h1234_5678, 32'h0BAD_0BAD, 5'd0, 5'd0, 5'd5, 1'b0, 5'd0, 1'b0);
    idle(5'd0, 5'd5);

    // Two pending writes to reg7 resolved one at a time.
    issue(5'd7, 5'd0, 5'd7);
    issue(5'd7, 5'd0, 5'd7);
    retire(5'd7, 32'h0000_0070, 5'd0, 5'd7);
    retire(5'd7, 32'h0000_0071, 5'd0, 5'd7);
    idle(5'd7, 5'd7);

    // Issue and retire reg9 together with one already pending.
    issue(5'd9, 5'd9, 5'd0);
    drive(1'b1, 1'b1, 32'h9999_0009, 32'd0, 5'd9, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0);
    idle(5'd9, 5'd0);
    retire(5'd9, 32'h0000_0099, 5'd9, 5'd9);

    // Saturation on reg3, then underflowing retire to reg4.
    for (int i = 0; i < 4; i++) issue(5'd3, 5'd3, 5'd0);
    idle(5'd3, 5'd4);
    retire(5'd4, 32'h4444_4444, 5'd4, 5'd3);
    idle(5'd4, 5'd3);

    // Clear and run random traffic over a small register window.
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd4, 1'b0, 5'd0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
            5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 6)),
            1'($urandom_range(0, 63) == 0));
    end

    // Retire counter wrap: preload 0xFFFFFFFF into the counter.
    idle(5'd5, 5'd0);
    #4;
    force dut.retireCount = 32'hFFFF_FFFF;
    #1;
    release dut.retireCount;
    #1;
    forced = 1'b0;
    if (bus.RetireCount !== 32'hFFFF_FFFF) begin
      // Preload did not stick after release; hold it across the retire edge.
      #1;
      force dut.retireCount = 32'hFFFF_FFFF;
      forced = 1'b1;
    end
    mRc = 32'hFFFF_FFFF;
    retire(5'd5, 32'h5555_AAAA, 5'd5, 5'd6);
    if (forced) begin
      @(posedge clk);
      #1;
      release dut.retireCount;
    end
    idle(5'd5, 5'd6);

    // Asynchronous reset between edges, with a write bypassed on RD1.
    issue(5'd2, 5'd5, 5'd2);
    issue(5'd2, 5'd5, 5'd2);
    drive(1'b1, 1'b0, 32'd0, 32'hCAFE_F00D, 5'd6, 5'd6, 5'd5, 1'b1, 5'd2, 1'b1);
    idle(5'd6, 5'd2);

    repeat (2) @(negedge clk);
    #5;
    total++;
    if (expQ.size() != 0 || popped != pushed) begin
      bad++;
      $display("FAIL drain got=%0d popped want=%0d", popped, pushed);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 RegWriteW  input  1  writeback enable from MEM/WB register.
REQ-004 MemtoRegW  input  1  result select: 1 = ReadDataW, 0 = ALUOutW.
REQ-005 ReadDataW  input  32  load data from writeback stage.
REQ-006 ALUOutW  input  32  ALU result from writeback stage.
REQ-007 WriteRegW  input  5  destination register index.
REQ-008 A1, A2  input  5 each  read-port register indices.
REQ-009 IssueValid  input  1  decode issues an instruction that will write IssueReg.
REQ-010 IssueReg  input  5  destination index of the issued instruction.
REQ-011 RD1, RD2  output  32 each  read data, combinational.
REQ-012 Busy1, Busy2  output  1 each  operand at A1/A2 still has an unresolved pending write.
REQ-013 ResultW  output  32  selected writeback value, combinational.
REQ-014 RetireCount  output  32  number of committed register writes.
REQ-015 Overflow, Underflow  output  1 each  sticky scoreboard error flags.

Function
REQ-016 ResultW SHALL equal ReadDataW when MemtoRegW=1, else ALUOutW.
REQ-017 Register file: 32 x 32-bit; register 0 SHALL always read 0 and ignore writes.
REQ-018 Write: on rising clk with RegWriteW=1 and WriteRegW!=0, reg[WriteRegW] <= ResultW.
REQ-019 Read bypass: RDn SHALL equal ResultW when RegWriteW=1, WriteRegW=An and An!=0; else reg[An] (0 when An=0).
REQ-020 Scoreboard: 2-bit pending count per register 1..31; register 0 never counted.
REQ-021 Issue event = IssueValid=1 and IssueReg!=0; Retire event = RegWriteW=1 and WriteRegW!=0.
REQ-022 Issue only to reg r: count[r] +1 at clock edge; Retire only to r: count[r] -1.
REQ-023 Issue and Retire to the same r in one cycle: count[r] unchanged.
REQ-024 Issue and Retire to different registers in one cycle: both updates applied.
REQ-025 Issue-only to r with count[r]=3: count stays 3; Overflow <= 1.
REQ-026 Retire-only to r with count[r]=0: count stays 0; Underflow <= 1; the register write still occurs.
REQ-027 Busyn SHALL be 1 when count[An]>=2, or when count[An]=1 and no Retire to An this cycle; else 0 (always 0 for An=0).
REQ-028 RetireCount SHALL increment by 1 (mod 2^32, wrapping to 0) on every Retire event.
REQ-029 Overflow/Underflow, once set, SHALL remain 1 until reset.
REQ-030 No read latency; write, scoreboard and counter latency: one clock edge.

Reset
REQ-031 rst=1 SHALL immediately clear all registers, all counts, RetireCount, Overflow and Underflow to 0, independent of clk.
REQ-032 While rst=1, writes, issues and retires SHALL be ignored; RD1/RD2 read 0 except through the bypass path.
REQ-033 rst asserted mid-operation SHALL discard all in-flight scoreboard state; no flag is raised by the discard.

Verification
REQ-034 Write reg5=0xDEADBEEF (MemtoRegW=0) with A1=5 in the same cycle -> RD1=0xDEADBEEF via bypass; next cycle, with RegWriteW=0, RD1=0xDEADBEEF from storage.
REQ-035 Write reg0=0x12345678 -> RD1 with A1=0 reads 0; RetireCount unchanged.
REQ-036 Issue reg7 twice, then one Retire to reg7 with A2=7 -> Busy2=1 during that cycle; a second Retire to reg7 -> Busy2=0 during that cycle; count[7]=0 afterwards.
REQ-037 Issue reg9 and Retire reg9 in the same cycle with count[9]=1 -> count[9] stays 1 and Busy=1 in the following cycle.
REQ-038 Issue reg3 four times with no retires -> Overflow=1 after the 4th edge, count[3]=3; a Retire to reg4 with count[4]=0 -> Underflow=1 and reg4 is written.
REQ-039 Preload RetireCount to 0xFFFFFFFF, then one Retire -> RetireCount=0; assert rst asynchronously between edges -> all outputs cleared before the next edge.
